// File: rtl/edge_detect.sv
// edge_detect
//   Per-bit edge detector. Each bit of the monitored input is compared with
//   its previously sampled value to flag rising (pe), falling (ne) and either
//   (ee) edges. Typical use: spotting the first cycle of a chip-select
//   assertion so a burst address counter can be loaded.
//
//   Without EDGE_DET_SYNC_EN the compare source is i itself, so an edge is
//   flagged in the same cycle the input changes (0-cycle latency).
//   With EDGE_DET_SYNC_EN defined, i first passes through a two-flop
//   synchronizer (free-running, not gated by ce). The outputs then come from
//   registered sources only, and each edge appears 2 clocks after i changes.
//
// Parameters
//   WID   number of independent input bits
//   INIT  reset value of the previous-sample register and sync stages
//
// Ports
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   ce    clock enable for the previous-sample register
//   i     [WID-1:0] monitored signal
//   pe    [WID-1:0] rising edge:  s & ~prev
//   ne    [WID-1:0] falling edge: ~s & prev
//   ee    [WID-1:0] either edge:  s ^ prev
module edge_detect #(
    parameter int             WID  = 1,
    parameter logic [WID-1:0] INIT = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic [WID-1:0] i,
    output logic [WID-1:0] pe,
    output logic [WID-1:0] ne,
    output logic [WID-1:0] ee
);

    logic [WID-1:0] s;
    logic [WID-1:0] prev_d;
    logic [WID-1:0] prev_q;

`ifdef EDGE_DET_SYNC_EN
    logic [WID-1:0] sync1_d;
    logic [WID-1:0] sync1_q;
    logic [WID-1:0] sync2_d;
    logic [WID-1:0] sync2_q;

    always_comb begin
        sync1_d = i;
        sync2_d = sync1_q;
    end

    // Synchronizer runs every clock; ce only gates the compare register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= INIT;
            sync2_q <= INIT;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign s = sync2_q;
`else
    assign s = i;
`endif

    always_comb begin
        prev_d = prev_q;
        if (ce) begin
            prev_d = s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= INIT;
        end else begin
            prev_q <= prev_d;
        end
    end

    // During reset s may still differ from INIT, so the outputs are
    // explicitly gated rather than relying on prev_q alone.
    always_comb begin
        pe = '0;
        ne = '0;
        ee = '0;
        if (rst) begin
            pe = s & ~prev_q;
            ne = ~s & prev_q;
            ee = s ^ prev_q;
        end
    end

endmodule

// File: tb/tb_edge_detect.sv
// Scoreboard bench for edge_detect (default build, WID=4, INIT=0).
// The stimulus process drives one directed vector per cycle shortly after the
// rising edge and pushes its hand-computed expected outputs into a queue. The
// monitor samples the DUT on each falling edge, pops one entry and compares.
module tb_edge_detect;

    localparam int WID = 4;

    logic           clk;
    logic           rst;
    logic           ce;
    logic [WID-1:0] i;
    logic [WID-1:0] pe;
    logic [WID-1:0] ne;
    logic [WID-1:0] ee;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic           rst;
        logic           ce;
        logic [WID-1:0] i;
        logic [WID-1:0] pe;
        logic [WID-1:0] ne;
        logic [WID-1:0] ee;
        string          name;
    } vec_t;

    typedef struct {
        logic [WID-1:0] pe;
        logic [WID-1:0] ne;
        logic [WID-1:0] ee;
        string          name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    bit   stim_done = 0;

    edge_detect #(
        .WID (WID),
        .INIT(4'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ce (ce),
        .i  (i),
        .pe (pe),
        .ne (ne),
        .ee (ee)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic c, input logic [WID-1:0] iv,
                       input logic [WID-1:0] p, input logic [WID-1:0] n,
                       input logic [WID-1:0] e, input string nm);
        vec_t v;
        v.rst = r; v.ce = c; v.i = iv; v.pe = p; v.ne = n; v.ee = e; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [WID-1:0] act,
                         input logic [WID-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the oldest entry.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            check({x.name, " pe"}, pe, x.pe);
            check({x.name, " ne"}, ne, x.ne);
            check({x.name, " ee"}, ee, x.ee);
            check({x.name, " pe&ne"}, pe & ne, '0);
            check({x.name, " ee=pe|ne"}, ee, pe | ne);
        end
    end

    initial begin
        int wait_cyc;
        // rst  ce  i     pe    ne    ee
        add(0, 1, 4'hF, 4'h0, 4'h0, 4'h0, "rst_hold_F");
        add(0, 1, 4'h5, 4'h0, 4'h0, 4'h0, "rst_hold_5");
        add(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, "rst_hold_0");
        add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, "release_i0");
        add(1, 1, 4'h1, 4'h1, 4'h0, 4'h1, "rise");
        add(1, 1, 4'h1, 4'h0, 4'h0, 4'h0, "rise_done");
        add(1, 1, 4'h0, 4'h0, 4'h1, 4'h1, "fall");
        add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, "fall_done");
        add(1, 0, 4'h1, 4'h1, 4'h0, 4'h1, "ce0_c1");
        add(1, 0, 4'h1, 4'h1, 4'h0, 4'h1, "ce0_c2");
        add(1, 0, 4'h1, 4'h1, 4'h0, 4'h1, "ce0_c3");
        add(1, 1, 4'h1, 4'h1, 4'h0, 4'h1, "ce1_sample");
        add(1, 1, 4'h1, 4'h0, 4'h0, 4'h0, "ce1_after");
        add(1, 1, 4'h5, 4'h4, 4'h0, 4'h4, "mb_to_5");
        add(1, 1, 4'h3, 4'h2, 4'h4, 4'h6, "mb_5_to_3");
        add(1, 1, 4'h3, 4'h0, 4'h0, 4'h0, "mb_hold_3");
        add(1, 1, 4'hC, 4'hC, 4'h3, 4'hF, "opposite");
        add(1, 1, 4'h3, 4'h3, 4'hC, 4'hF, "opposite2");
        add(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, "rst_mid");
        add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, "edge_lost");
        add(1, 1, 4'hF, 4'hF, 4'h0, 4'hF, "rise_all");
        add(1, 1, 4'hF, 4'h0, 4'h0, 4'h0, "rise_all_done");

        rst = 1'b0;
        ce  = 1'b1;
        i   = '0;

        foreach (vecs[k]) begin
            exp_t x;
            @(posedge clk);
            #1;
            rst = vecs[k].rst;
            ce  = vecs[k].ce;
            i   = vecs[k].i;
            x.pe = vecs[k].pe; x.ne = vecs[k].ne; x.ee = vecs[k].ee;
            x.name = vecs[k].name;
            sb.push_back(x);
        end

        // Asynchronous reset in the middle of a cycle with a pending edge.
        @(posedge clk);
        #1;
        i = 4'h0;
        #2;
        checks++;
        if (pe !== 4'h0 || ne !== 4'hF || ee !== 4'hF) begin
            errors++;
            $display("FAIL async_pre: got pe=%h ne=%h ee=%h expected pe=0 ne=f ee=f",
                     pe, ne, ee);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (pe !== 4'h0 || ne !== 4'h0 || ee !== 4'h0) begin
            errors++;
            $display("FAIL async_rst: got pe=%h ne=%h ee=%h expected all 0",
                     pe, ne, ee);
        end
        stim_done = 1;

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
